fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, FIFO write-data width.
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum beats per grant (1..16).
REQ-004 SHALL have port wclk  input  1  write-domain clock; one clock only, all logic on rising edge.
REQ-005 SHALL have port wrst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester write request, held while data is pending.
REQ-007 SHALL have port req_data  input  NUM_REQ x DATA_WIDTH  per-requester write data.
REQ-008 SHALL have port gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
REQ-009 SHALL have port ack  output  NUM_REQ  combinational beat accept, ack[i] = gnt[i] & req[i] & ~wfull.
REQ-010 SHALL have port wfull  input  1  FIFO full flag from the write-pointer logic.
REQ-011 SHALL have port winc  output  1  FIFO write enable, equal to OR of ack.
REQ-012 SHALL have port wdata  output  DATA_WIDTH  req_data of the granted requester; zero when gnt is all-zero.

Function
REQ-013 SHALL implement FSM states IDLE and GRANT.
REQ-014 SHALL stay in IDLE while req is zero; in IDLE, any req bit SHALL cause a round-robin pick and a move to GRANT, with gnt visible on the next cycle.
REQ-015 SHALL perform the round-robin search starting at index last_owner+1 mod NUM_REQ and wrapping; last_owner itself is searched last.
REQ-016 SHALL transfer one beat per cycle in which ack[owner]=1; beat_cnt increments only on accepted beats.
REQ-017 SHALL hold owner, gnt and beat_cnt unchanged while wfull=1, with winc=0 and no timeout.
REQ-018 SHALL release the grant when req[owner]=0 in GRANT, or on the accepted beat with beat_cnt=BURST_LEN-1.
REQ-019 SHALL, on release, re-arbitrate in the same cycle, update last_owner to the released owner, and enter GRANT with the new owner next cycle, or IDLE if req (owner bit excluded when dropped) is zero.
REQ-020 SHALL allow back-to-back bursts without a bubble on burst-limit release: a sole continuous requester is re-granted and winc stays high.
REQ-021 SHALL insert exactly one idle cycle (winc=0) when the owner drops req.
REQ-022 SHALL size beat_cnt to clog2(BURST_LEN)+1 bits, reset to 0 on every new grant, and never wrap within a grant.
REQ-023 SHALL never assert more than one gnt bit, and SHALL never assert winc while wfull=1.

Reset
REQ-024 SHALL, while wrst=1, force state=IDLE, gnt=0, beat_cnt=0 and last_owner=NUM_REQ-1, so requester 0 wins first; winc, ack and wdata SHALL be 0.
REQ-025 SHALL abort any burst on reset assertion mid-grant, with no further winc until a new grant after release.

Configuration
REQ-026 SHALL compile per-requester statistics only when macro FIFO_WR_ARB_STATS_EN is defined: output beat_count, NUM_REQ x 16 bits, counting accepted beats per requester, saturating at 16'hFFFF, cleared by wrst.
REQ-027 SHALL, without FIFO_WR_ARB_STATS_EN, have no beat_count port and no counter logic; all other behaviour identical.

Structure
REQ-028 SHALL place the state enum (IDLE, GRANT) and the default parameter constants in shared package fifo_arb_pkg.
REQ-029 SHALL implement the round-robin search as one combinational sub-module rr_pick (inputs req and last_owner, outputs one-hot pick and valid).

Verification
REQ-030 SHALL cover: reset release, req=4'b0101, wfull=0 -> gnt=0001 next cycle, 4 beats, then gnt=0100 with no bubble, 4 beats.
REQ-031 SHALL cover: req[2] held, wfull pulsed high for 3 cycles mid-burst -> winc=0 for those 3 cycles, gnt=0100 held, burst completes with exactly 4 beats total.
REQ-032 SHALL cover: owner 1 drops req after 2 beats while req[3]=1 -> one winc=0 cycle, then gnt=1000.
REQ-033 SHALL cover: req=4'b1111 for 32 cycles with wfull=0 -> grant order 0,1,2,3,0,... with 4 beats each and winc high every cycle after the first grant.
REQ-034 SHALL cover: wrst asserted mid-burst -> gnt=0, winc=0 immediately; after release with req=4'b1000 -> gnt=1000 next cycle.
REQ-035 SHALL cover, with FIFO_WR_ARB_STATS_EN defined: 70000 accepted beats on requester 0 -> beat_count[0]=16'hFFFF, other counts unaffected.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write arbiter: default parameter values,
// the arbiter FSM state type and a one-hot to index helper.
// Optional feature macro used by the top level: FIFO_WR_ARB_STATS_EN.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_LEN  = 4;
    localparam int STAT_W         = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index of the set bit in a one-hot vector of up to 8 bits (0 if none).
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundle of requester handshake and FIFO write-side signals.
//   req      : per-requester write request
//   req_data : per-requester write data
//   gnt      : one-hot grant
//   ack      : per-requester beat accept
//   wfull    : FIFO full flag
//   winc     : FIFO write enable
//   wdata    : FIFO write data
// Modports: master (requesters + FIFO side), slave (the arbiter).
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 gnt;
    logic [NUM_REQ-1:0]                 ack;
    logic                               wfull;
    logic                               winc;
    logic [DATA_WIDTH-1:0]              wdata;

    modport master (
        output req, req_data, wfull,
        input  gnt, ack, winc, wdata
    );

    modport slave (
        input  req, req_data, wfull,
        output gnt, ack, winc, wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. Starts at last_owner+1 (mod NUM_REQ),
// wraps, and visits last_owner itself last.
//   req        : request vector
//   last_owner : index of the previous owner
//   pick       : one-hot winner (zero when no request)
//   valid      : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    // First requester found after last_owner wins; later hits are masked by valid.
    always_comb begin
        logic hit_s;
        int   idx_s;
        pick  = '0;
        valid = 1'b0;
        hit_s = 1'b0;
        idx_s = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s       = (int'(last_owner) + k) % NUM_REQ;
            hit_s       = !valid && req[idx_s];
            pick[idx_s] = pick[idx_s] | hit_s;
            valid       = valid | hit_s;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter granting one of NUM_REQ requesters write access to a
// FIFO for bursts of up to BURST_LEN accepted beats.
//   wclk : write-domain clock (rising edge)
//   wrst : asynchronous active-high reset
//   bus  : fifo_wr_arbiter_if.slave (req, req_data, wfull in; gnt, ack,
//          winc, wdata out)
//   beat_count : per-requester saturating accepted-beat counters, present
//          only when FIFO_WR_ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                wclk,
    input  logic                wrst,
    fifo_wr_arbiter_if.slave    bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][STAT_W-1:0] beat_count
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BCW   = $clog2(BURST_LEN) + 1;

    arb_state_e          state_r, state_n;
    logic [NUM_REQ-1:0]  gnt_r, gnt_n;
    logic [NUM_REQ-1:0]  ack_s, pick_s;
    logic                pick_valid_s, owner_req_s, beat_ok_s, release_s;
    logic [IDX_W-1:0]    last_owner_r, last_owner_n, owner_idx_s, search_from_s;
    logic [BCW-1:0]      beat_cnt_r, beat_cnt_n;
    logic [DATA_WIDTH-1:0] wdata_s;

    // Beat accept and owner status derived from the registered grant.
    always_comb begin
        ack_s       = gnt_r & bus.req & {NUM_REQ{~bus.wfull}};
        owner_req_s = |(gnt_r & bus.req);
        beat_ok_s   = |ack_s;
        owner_idx_s = IDX_W'(oh_to_idx(8'(gnt_r)));
    end

    // Write data mux; an all-zero grant yields zero data.
    always_comb begin
        wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wdata_s = wdata_s | (bus.req_data[i] & {DATA_WIDTH{gnt_r[i]}});
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.ack   = ack_s;
    assign bus.winc  = beat_ok_s;
    assign bus.wdata = wdata_s;

    // While granted, the current owner becomes the search origin so a release
    // re-arbitrates in the same cycle with the new last_owner already applied.
    assign search_from_s = (state_r == GRANT) ? owner_idx_s : last_owner_r;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (bus.req),
        .last_owner (search_from_s),
        .pick       (pick_s),
        .valid      (pick_valid_s)
    );

    // Next-state, next-grant and beat counter logic.
    always_comb begin
        state_n      = state_r;
        gnt_n        = gnt_r;
        beat_cnt_n   = beat_cnt_r;
        last_owner_n = last_owner_r;
        release_s    = 1'b0;
        case (state_r)
            IDLE: begin
                beat_cnt_n = '0;
                if (pick_valid_s) begin
                    state_n = GRANT;
                    gnt_n   = pick_s;
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
            end
            GRANT: begin
                release_s = !owner_req_s ||
                            (beat_ok_s && (beat_cnt_r == BCW'(BURST_LEN - 1)));
                if (release_s) begin
                    last_owner_n = owner_idx_s;
                    beat_cnt_n   = '0;
                    if (pick_valid_s) begin
                        state_n = GRANT;
                        gnt_n   = pick_s;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end else if (beat_ok_s) begin
                    beat_cnt_n = beat_cnt_r + BCW'(1);
                end else begin
                    beat_cnt_n = beat_cnt_r;
                end
            end
            default: begin
                state_n    = IDLE;
                gnt_n      = '0;
                beat_cnt_n = '0;
            end
        endcase
    end

    // State register; reset leaves last_owner at NUM_REQ-1 so requester 0 wins first.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_r      <= IDLE;
            gnt_r        <= '0;
            beat_cnt_r   <= '0;
            last_owner_r <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_r      <= state_n;
            gnt_r        <= gnt_n;
            beat_cnt_r   <= beat_cnt_n;
            last_owner_r <= last_owner_n;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    // Per-requester accepted-beat counters, saturating at all-ones.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            beat_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack_s[i] && (beat_count[i] != 16'hFFFF)) begin
                    beat_count[i] <= beat_count[i] + 16'd1;
                end else begin
                    beat_count[i] <= beat_count[i];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4).
// Each step drives one cycle of inputs, queues the expected grant/winc/ack/
// wdata for that cycle and compares them shortly after the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic       winc;
        logic [3:0] ack;
        logic [7:0] wdata;
    } exp_t;

    logic wclk;
    logic wrst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
    logic [3:0][15:0] bcount;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .BURST_LEN  (4)
    ) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .beat_count (bcount)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [7:0] data_of(input logic [3:0] g);
        logic [7:0] d;
        d = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) d = 8'hA0 + 8'(i);
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic rv, input logic [3:0] r,
                        input logic wf, input logic [3:0] eg, input logic ew);
        exp_t e;
        @(negedge wclk);
        wrst      = rv;
        bus.req   = r;
        bus.wfull = wf;
        e.tag   = tag;
        e.gnt   = eg;
        e.winc  = ew;
        e.ack   = ew ? eg : 4'b0000;
        e.wdata = data_of(eg);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".gnt"},   32'(bus.gnt),   32'(e.gnt));
        chk({e.tag, ".winc"},  32'(bus.winc),  32'(e.winc));
        chk({e.tag, ".ack"},   32'(bus.ack),   32'(e.ack));
        chk({e.tag, ".wdata"}, 32'(bus.wdata), 32'(e.wdata));
    endtask

    initial begin
        wrst      = 1'b1;
        bus.req   = 4'b0000;
        bus.wfull = 1'b0;
        for (int i = 0; i < 4; i++) bus.req_data[i] = 8'hA0 + 8'(i);

        // Reset holds everything quiet even with requests present.
        step("rst0", 1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0);
        step("rst1", 1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0);

        // Two requesters: 4 beats each, no bubble at the hand-over.
        step("a_idle", 1'b0, 4'b0101, 1'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) step("a_r0", 1'b0, 4'b0101, 1'b0, 4'b0001, 1'b1);
        for (int k = 0; k < 4; k++) step("a_r2", 1'b0, 4'b0101, 1'b0, 4'b0100, 1'b1);
        step("a_drop", 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0);
        step("a_end",  1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // wfull stalls a burst for 3 cycles; 4 beats total.
        step("b_idle", 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0);
        step("b_beat1", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1);
        for (int k = 0; k < 3; k++) step("b_full", 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0);
        for (int k = 0; k < 3; k++) step("b_beat", 1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1);
        step("b_drop", 1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0);
        step("b_end",  1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // Owner 1 drops after 2 beats with requester 3 waiting: one idle cycle.
        step("c_idle", 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0);
        step("c_beat", 1'b0, 4'b1010, 1'b0, 4'b0010, 1'b1);
        step("c_beat", 1'b0, 4'b1010, 1'b0, 4'b0010, 1'b1);
        step("c_gap",  1'b0, 4'b1000, 1'b0, 4'b0010, 1'b0);
        step("c_r3",   1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1);
        step("c_drop", 1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0);
        step("c_end",  1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        // All four requesting: rotation 0,1,2,3,0,... with 4 beats each.
        step("d_idle", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
        for (int k = 1; k < 32; k++) begin
            step("d_rr", 1'b0, 4'b1111, 1'b0, 4'(4'b0001 << (((k - 1) / 4) % 4)), 1'b1);
        end
        step("d_last", 1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1);
        step("d_wrap", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1);

        // Reset mid-burst clears grant at once; requester 3 is granted after.
        step("e_rst",  1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0);
        step("e_rst",  1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0);
        step("e_idle", 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0);
        step("e_r3",   1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1);
        step("e_swap", 1'b0, 4'b0001, 1'b0, 4'b1000, 1'b0);

`ifdef FIFO_WR_ARB_STATS_EN
        // Continuous single requester: counter 0 saturates, others untouched.
        for (int k = 0; k < 70000; k++) @(negedge wclk);
        #1;
        chk("s_cnt0", 32'(bcount[0]), 32'h0000FFFF);
        chk("s_cnt1", 32'(bcount[1]), 32'h00000000);
        chk("s_cnt2", 32'(bcount[2]), 32'h00000000);
        chk("s_cnt3", 32'(bcount[3]), 32'h00000001);
`else
        step("f_beat", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1);
`endif
        step("f_drop", 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0);
        step("f_end",  1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
